// File: rtl/timer_irq_ctrl.sv
// HuC6280 timer (CET_n) and interrupt controller (CECG_n) bus responder.
// Prescaled 7-bit reload down-counter raises TIQ; IRQ1/IRQ2 are synchronized external levels.
module timer_irq_ctrl #(
  parameter int PRESCALE = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       RE,
  input  logic       WE,
  input  logic       CET_n,
  input  logic       CECG_n,
  input  logic [1:0] addr,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  input  logic       irq1_ext_n,
  input  logic       irq2_ext_n,
  output logic       tiq_n,
  output logic       irq1_n,
  output logic       irq2_n
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [6:0]    reload;
  logic [6:0]    counter;
  logic          en;
  logic [PW-1:0] prescaler;
  logic [2:0]    mask;
  logic          tiq_pend;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic          irq1_pend;
  logic          irq2_pend;

  logic wr;
  logic wr_reload;
  logic wr_en;
  logic wr_mask;
  logic wr_ack;
  logic start;
  logic stop;
  logic run;
  logic tick;
  logic underflow;
  logic unused;

  assign wr        = ce & WE;
  assign wr_reload = wr & ~CET_n & ~addr[0];
  assign wr_en     = wr & ~CET_n & addr[0];
  assign wr_mask   = wr & ~CECG_n & (addr == 2'd2);
  assign wr_ack    = wr & ~CECG_n & (addr == 2'd3);

  // A disabling write suppresses a terminal tick landing in the same cycle.
  assign start     = wr_en & d_in[0] & ~en;
  assign stop      = wr_en & ~d_in[0];
  assign run       = ce & en & ~stop;
  assign tick      = run & (prescaler == PRE_LAST);
  assign underflow = tick & (counter == 7'd0);

  assign unused    = d_in[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      en        <= 1'b0;
      prescaler <= '0;
      counter   <= 7'd0;
    end else begin
      if (wr_en) en <= d_in[0];

      if (start || stop || tick) prescaler <= '0;
      else if (run)              prescaler <= prescaler + 1'b1;

      if (start)     counter <= reload;
      else if (tick) counter <= underflow ? reload : counter - 7'd1;
    end
  end

  // Reload is read by the counter before this write lands, so an underflow
  // coinciding with a reload write still loads the previous value.
  always_ff @(posedge clk) begin
    if (reset) begin
      reload   <= 7'd0;
      mask     <= 3'b000;
      tiq_pend <= 1'b0;
    end else begin
      if (wr_reload) reload <= d_in[6:0];
      if (wr_mask)   mask   <= d_in[2:0];
      if (underflow)   tiq_pend <= 1'b1;
      else if (wr_ack) tiq_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else if (ce) begin
      sync1 <= {irq1_ext_n, irq2_ext_n};
      sync2 <= sync1;
    end
  end

  assign irq1_pend = ~sync2[1];
  assign irq2_pend = ~sync2[0];

  always_comb begin
    d_out = 8'h00;
    if (RE) begin
      if (!CET_n) begin
        d_out = {1'b0, counter};
      end else if (!CECG_n) begin
        case (addr)
          2'd2:    d_out = {5'b0, mask};
          2'd3:    d_out = {5'b0, tiq_pend, irq1_pend, irq2_pend};
          default: d_out = 8'h00;
        endcase
      end
    end
  end

  assign tiq_n  = ~(tiq_pend & ~mask[2]);
  assign irq1_n = ~(irq1_pend & ~mask[1]);
  assign irq2_n = ~(irq2_pend & ~mask[0]);

endmodule
